// File: rtl/ama_riscv_pipe_monitor_pkg.sv
// ama_riscv_pipe_monitor_pkg: shared instruction encodings and flush-run FSM states for the pipeline monitor.
package ama_riscv_pipe_monitor_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [31:0] INST_FLUSH = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        RUN
    } flush_fsm_t;

endpackage

// File: rtl/ama_riscv_pipe_monitor_if.sv
// ama_riscv_pipe_monitor_if: observation bus between the core and the pipeline monitor.
// master drives en/clr/stage_inst/stage_stall/wbk_pc/hist_rd_idx and reads the statistics;
// slave (the monitor) consumes the stage view and drives counters, flush-run lengths and history reads.
interface ama_riscv_pipe_monitor_if #(
    parameter int STAGES     = 4,
    parameter int INST_W     = 32,
    parameter int CNT_W      = 32,
    parameter int HIST_DEPTH = 8
);
    localparam int PW = $clog2(HIST_DEPTH);

    logic                       en;
    logic                       clr;
    logic [STAGES*INST_W-1:0]   stage_inst;
    logic [STAGES-1:0]          stage_stall;
    logic [31:0]                wbk_pc;
    logic [STAGES*CNT_W-1:0]    nop_cnt;
    logic [STAGES*CNT_W-1:0]    flush_cnt;
    logic [STAGES*CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]           retired_cnt;
    logic [CNT_W-1:0]           flush_run_cur;
    logic [CNT_W-1:0]           flush_run_max;
    logic [PW-1:0]              hist_rd_idx;
    logic [INST_W-1:0]          hist_rd_inst;
    logic [31:0]                hist_rd_pc;
    logic [PW:0]                hist_cnt;

    modport master (
        output en, clr, stage_inst, stage_stall, wbk_pc, hist_rd_idx,
        input  nop_cnt, flush_cnt, stall_cnt, retired_cnt, flush_run_cur, flush_run_max,
               hist_rd_inst, hist_rd_pc, hist_cnt
    );

    modport slave (
        input  en, clr, stage_inst, stage_stall, wbk_pc, hist_rd_idx,
        output nop_cnt, flush_cnt, stall_cnt, retired_cnt, flush_run_cur, flush_run_max,
               hist_rd_inst, hist_rd_pc, hist_cnt
    );

endinterface

// File: rtl/ama_riscv_sat_cnt.sv
// ama_riscv_sat_cnt: W-bit event counter that sticks at all-ones.
// Ports: clk, rst (async, active-high), clr (sync clear, wins over inc), inc (count enable), cnt (registered count).
module ama_riscv_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
    assign cnt   = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ama_riscv_pipe_monitor.sv
// ama_riscv_pipe_monitor: classifies every pipeline stage each cycle, keeps saturating event counters,
// tracks flush-bubble runs at the retiring stage and records recent retirements in a readable ring buffer.
// Ports: clk, rst (async, active-high), mon (slave side of ama_riscv_pipe_monitor_if).
module ama_riscv_pipe_monitor
    import ama_riscv_pipe_monitor_pkg::*;
#(
    parameter int STAGES     = 4,
    parameter int INST_W     = 32,
    parameter int CNT_W      = 32,
    parameter int HIST_DEPTH = 8
) (
    input logic                     clk,
    input logic                     rst,
    ama_riscv_pipe_monitor_if.slave mon
);

    localparam int L  = STAGES - 1;
    localparam int PW = $clog2(HIST_DEPTH);
    localparam int CW = PW + 1;

    logic [STAGES-1:0] is_nop, is_flush, is_stall;
    logic [INST_W-1:0] last_inst;
    logic              retire_ev, hist_we, fsm_step;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [INST_W-1:0] inst;
        assign inst        = mon.stage_inst[i*INST_W +: INST_W];
        assign is_stall[i] = mon.stage_stall[i];
        // A stalled stage is only counted as stalled; its content is not classified.
        assign is_nop[i]   = !is_stall[i] && inst == INST_W'(INST_NOP);
        assign is_flush[i] = !is_stall[i] && inst == INST_W'(INST_FLUSH);
        ama_riscv_sat_cnt #(.W(CNT_W)) u_nop (
            .clk(clk), .rst(rst), .clr(mon.clr), .inc(mon.en && is_nop[i]),
            .cnt(mon.nop_cnt[i*CNT_W +: CNT_W])
        );
        ama_riscv_sat_cnt #(.W(CNT_W)) u_flush (
            .clk(clk), .rst(rst), .clr(mon.clr), .inc(mon.en && is_flush[i]),
            .cnt(mon.flush_cnt[i*CNT_W +: CNT_W])
        );
        ama_riscv_sat_cnt #(.W(CNT_W)) u_stall (
            .clk(clk), .rst(rst), .clr(mon.clr), .inc(mon.en && is_stall[i]),
            .cnt(mon.stall_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign last_inst = mon.stage_inst[L*INST_W +: INST_W];
    assign retire_ev = !is_stall[L] && !is_nop[L] && !is_flush[L];
    assign hist_we   = mon.en && !mon.clr && retire_ev;
    assign fsm_step  = mon.en && !is_stall[L];

    ama_riscv_sat_cnt #(.W(CNT_W)) u_retired (
        .clk(clk), .rst(rst), .clr(mon.clr), .inc(mon.en && retire_ev),
        .cnt(mon.retired_cnt)
    );

    flush_fsm_t       state_q;
    logic [CNT_W-1:0] run_cur_q, run_max_q;

    // Stalled cycles at the last stage leave the run state untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            run_cur_q <= '0;
            run_max_q <= '0;
        end else if (mon.clr) begin
            state_q   <= IDLE;
            run_cur_q <= '0;
            run_max_q <= '0;
        end else if (fsm_step) begin
            if (is_flush[L]) begin
                state_q   <= RUN;
                run_cur_q <= (state_q == IDLE) ? CNT_W'(1) : run_cur_q + CNT_W'(!(&run_cur_q));
            end else if (state_q == RUN) begin
                state_q   <= IDLE;
                run_max_q <= (run_cur_q > run_max_q) ? run_cur_q : run_max_q;
                run_cur_q <= '0;
            end
        end
    end

    assign mon.flush_run_cur = run_cur_q;
    assign mon.flush_run_max = run_max_q;

    logic [INST_W-1:0] inst_mem [HIST_DEPTH];
    logic [31:0]       pc_mem   [HIST_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_addr;
    logic [CW-1:0]     hist_cnt_q, hist_cnt_d;
    logic [INST_W-1:0] rd_inst_q, rd_inst_d;
    logic [31:0]       rd_pc_q, rd_pc_d;
    logic              rd_hit;

    // The read address wraps naturally in PW bits, so idx 0 is always the newest entry.
    always_comb begin
        wr_ptr_d   = mon.clr ? '0 : hist_we ? wr_ptr_q + PW'(1) : wr_ptr_q;
        hist_cnt_d = mon.clr ? '0 : (hist_we && hist_cnt_q != CW'(HIST_DEPTH)) ? hist_cnt_q + CW'(1) : hist_cnt_q;
        rd_addr    = wr_ptr_q - PW'(1) - mon.hist_rd_idx;
        rd_hit     = {1'b0, mon.hist_rd_idx} < hist_cnt_q;
        rd_inst_d  = rd_hit ? inst_mem[rd_addr] : '0;
        rd_pc_d    = rd_hit ? pc_mem[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (hist_we) begin
            inst_mem[wr_ptr_q] <= last_inst;
            pc_mem[wr_ptr_q]   <= mon.wbk_pc;
        end
    end

    // Reads keep operating while en=0; only clr/rst hide the stored entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            hist_cnt_q <= '0;
            rd_inst_q  <= '0;
            rd_pc_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            hist_cnt_q <= hist_cnt_d;
            rd_inst_q  <= rd_inst_d;
            rd_pc_q    <= rd_pc_d;
        end
    end

    assign mon.hist_rd_inst = rd_inst_q;
    assign mon.hist_rd_pc   = rd_pc_q;
    assign mon.hist_cnt     = hist_cnt_q;

endmodule
